// File: rtl/uart_rx_os16.sv
// ============================================================================
//  Module   : uart_rx_os16
//  Purpose  : UART receiver with 16x oversampling; byte strobe and framing-error strobe
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_os16 #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 framing_err,
   output logic                 busy
);

   localparam int c_TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int c_BW = $clog2(DATA_BITS + 1);
   localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(OVERSAMPLE / 2 - 1);
   localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OVERSAMPLE - 1);
   localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [c_TW-1:0]        tick_q, tick_d;
   logic [c_BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   busy_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   // Synchronizer resets to idle-high so leaving reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '1;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if (baud_tick) begin
         tick_d = (tick_q == c_TICK_LAST) ? '0 : tick_q + 1'b1;
         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  state_d = S_START;
                  tick_d  = '0;
               end
            end
            S_START: begin
               if (tick_q == c_TICK_MID) begin
                  if (!rx_s) begin
                     state_d = S_DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_DATA: begin
               // Counter was zeroed mid start bit, so reaching the last count is mid-bit.
               if (tick_q == c_TICK_LAST) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == c_BIT_LAST) state_d = S_STOP;
               end
            end
            S_STOP: begin
               if (tick_q == c_TICK_LAST) begin
                  if (rx_s) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign framing_err = ferr_q;
   assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
// ============================================================================
//  Module   : tb_uart_rx_os16
//  Purpose  : Scoreboard bench for uart_rx_os16 (directed scenarios plus random frames)
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_os16;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       baud_tick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       framing_err;
   logic       busy;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         phase   = 0;
   exp_t       exp_q[$];
   logic [7:0] last_good = 8'h00;

   uart_rx_os16 #(
      .DATA_BITS   (8),
      .OVERSAMPLE  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .baud_tick   (baud_tick),
      .rx          (rx),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .framing_err (framing_err),
      .busy        (busy)
   );

   initial forever #5 clk = ~clk;

   // One baud tick every 4 clk; phase lets stimulus place edges between ticks.
   initial forever begin
      @(negedge clk);
      phase     = (phase + 1) % 4;
      baud_tick = (phase == 0);
   end

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (64) step();
   endtask

   // Reference model: a good stop bit yields the byte, a low stop bit yields an
   // error pulse with data_out still holding the previous good byte.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                             input int idle_bits, input bit chk_busy);
      if (stop_ok) begin
         exp_q.push_back('{err: 1'b0, data: d});
         last_good = d;
      end else begin
         exp_q.push_back('{err: 1'b1, data: last_good});
      end
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         drive_bit(d[i]);
         if (chk_busy && i == 3) chk("busy_mid_frame", busy, 1);
      end
      drive_bit(stop_ok);
      if (chk_busy) chk("busy_after_stop", busy, stop_ok ? 0 : 1);
      repeat (idle_bits) drive_bit(1'b1);
   endtask

   initial begin : monitor
      logic prev_dv;
      logic prev_fe;
      exp_t e;
      prev_dv = 1'b0;
      prev_fe = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && (data_valid || framing_err)) begin
            chk("pulse_exclusive", int'(data_valid & framing_err), 0);
            chk("pulse_width", int'((data_valid & prev_dv) | (framing_err & prev_fe)), 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", int'({data_valid, framing_err}), 0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind_err", int'(framing_err), int'(e.err));
               chk("data_out", int'(data_out), int'(e.data));
            end
         end
         prev_dv = data_valid;
         prev_fe = framing_err;
      end
   end

   initial begin : stimulus
      int busy_cnt;
      int gate_bad;
      int wait_cnt;
      logic [7:0] d;

      reset = 1'b1;
      rx    = 1'b1;
      repeat (4) step();
      chk("reset_data_out", data_out, 0);
      chk("reset_data_valid", data_valid, 0);
      chk("reset_framing_err", framing_err, 0);
      chk("reset_busy", busy, 0);
      reset = 1'b0;
      repeat (64) step();
      chk("idle_busy", busy, 0);

      send_frame(8'hA5, 1'b1, 1, 1'b1);

      // Start glitch: 3 ticks low must be rejected at the mid-start check.
      busy_cnt = 0;
      rx = 1'b0;
      repeat (12) begin step(); busy_cnt += int'(busy); end
      rx = 1'b1;
      repeat (88) begin step(); busy_cnt += int'(busy); end
      chk("glitch_busy_len_ok", int'(busy_cnt >= 30 && busy_cnt <= 34), 1);
      chk("glitch_busy_end", busy, 0);

      send_frame(8'h3C, 1'b0, 0, 1'b1);
      rx = 1'b0;
      repeat (40 * 64) step();
      chk("break_data_out_held", data_out, 8'hA5);
      chk("break_busy", busy, 1);
      drive_bit(1'b1);
      chk("break_exit_busy", busy, 0);
      send_frame(8'h11, 1'b1, 1, 1'b0);

      send_frame(8'h00, 1'b1, 0, 1'b0);
      send_frame(8'hFF, 1'b1, 1, 1'b0);

      // Short low pulses placed between ticks must never be seen.
      gate_bad = 0;
      for (int g = 0; g < 16; g++) begin
         do step(); while (phase != 1);
         rx = 1'b0;
         step();
         rx = 1'b1;
         repeat (6) begin step(); gate_bad += int'(busy); end
      end
      chk("tick_gating_busy", gate_bad, 0);

      // Asynchronous reset during data bit 3 of 0x77.
      d  = 8'h77;
      rx = 1'b0;
      repeat (64) step();
      for (int i = 0; i < 3; i++) drive_bit(d[i]);
      rx = d[3];
      repeat (30) step();
      #2;
      reset = 1'b1;
      #1;
      chk("midreset_data_out", data_out, 0);
      chk("midreset_data_valid", data_valid, 0);
      chk("midreset_framing_err", framing_err, 0);
      chk("midreset_busy", busy, 0);
      last_good = 8'h00;
      rx = 1'b1;
      repeat (5) step();
      reset = 1'b0;
      repeat (64) step();
      send_frame(8'h5A, 1'b1, 1, 1'b0);

      for (int r = 0; r < 16; r++) begin
         d = 8'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            send_frame(d, 1'b0, 0, 1'b0);
            repeat ($urandom_range(0, 3)) drive_bit(1'b0);
            drive_bit(1'b1);
         end else begin
            send_frame(d, 1'b1, $urandom_range(0, 2), 1'b0);
         end
      end

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 3000) begin
         step();
         wait_cnt++;
      end
      chk("scoreboard_drained", exp_q.size(), 0);
      repeat (200) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
